dot_sched: RTL and testbench
============================

DOT_SCHED -- requirements
Module: dot_sched

Interface
REQ-001 Parameter R, default 4: number of requesters sharing one dot engine; legal range 2..16.
REQ-002 Parameter TIMEOUT, default 1024: maximum BUSY cycles before an operation is abandoned; legal range >= 4.
REQ-003 Derived constant SW = clog2(R): width of the requester index.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port req, input, R: per-requester operation request, level; the requester holds it until granted.
REQ-007 Port gnt, output, R: one-hot, single-cycle grant to the selected requester.
REQ-008 Port sel, output, SW: index of the current owner; drives the operand mux in front of the dot engine.
REQ-009 Port eng_start, output, 1: single-cycle start pulse to the dot engine.
REQ-010 Port eng_done, input, 1: engine done, treated as a level (may stay high after completion).
REQ-011 Port rsp_valid, output, R: one-hot, single-cycle completion strobe to the owner.
REQ-012 Port rsp_err, output, 1: qualifies rsp_valid; 1 means the operation timed out.
REQ-013 Port err, output, 1: sticky timeout flag.
REQ-014 Port err_clr, input, 1: clears err.
REQ-015 Port busy, output, 1: high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, GRANT, ISSUE, BUSY, RESP; outputs are decoded from registered state only (Moore).
REQ-017 IDLE: if req != 0, latch the round-robin winner into sel and go to GRANT; otherwise stay in IDLE.
REQ-018 Round-robin: search starts at pointer ptr (reset 0) and ascends with wrap; on a grant, ptr <= winner+1 mod R.
REQ-019 GRANT: gnt[sel]=1 for one cycle, then go to ISSUE.
REQ-020 ISSUE: eng_start=1 for one cycle, clear bsy_cnt to 0, then go to BUSY.
REQ-021 BUSY: bsy_cnt increments each cycle, saturating at TIMEOUT-1.
REQ-022 BUSY, done: eng_done is ignored while bsy_cnt==0 (stale-done guard); eng_done with bsy_cnt>=1 goes to RESP with rsp_err=0.
REQ-023 BUSY, timeout: bsy_cnt==TIMEOUT-1 with no qualifying eng_done goes to RESP with rsp_err=1 and sets err.
REQ-024 BUSY, simultaneous events: a qualifying eng_done in the timeout cycle wins, giving rsp_err=0 and err unchanged.
REQ-025 RESP: rsp_valid[sel]=1 and rsp_err valid for one cycle, then go to IDLE.
REQ-026 Changes on req outside IDLE are ignored.
REQ-027 A req dropped before IDLE samples it is never granted.
REQ-028 Minimum request-to-response latency: 5 cycles (GRANT, ISSUE, BUSY×2, RESP), giving a back-to-back period of 6 cycles.
REQ-029 sel holds its value from GRANT through RESP.
REQ-030 err clearing: err_clr clears err; if err_clr and a set event occur in the same cycle, set wins.

Reset
REQ-031 On rst: state=IDLE, ptr=0, sel=0, bsy_cnt=0, err=0.
REQ-032 During reset: gnt, eng_start, rsp_valid, rsp_err and busy are all 0.
REQ-033 Reset mid-operation abandons the owner with no rsp_valid issued; the engine is not signalled, and its stale eng_done is masked by REQ-022 on the next operation.

Structure
REQ-034 Package dot_sched_pkg holds the state enum type and the default TIMEOUT constant.
REQ-035 Arbitration lives in one sub-module, rr_arbiter (inputs req and ptr; outputs winner index and valid), which is purely combinational.
REQ-036 All state, counter and pointer registers live in dot_sched.

Verification
REQ-037 Single request: R=4, req=0010, eng_done 3 cycles after eng_start -> gnt=0010 at T+1, eng_start at T+2, rsp_valid=0010 with rsp_err=0.
REQ-038 Fairness: req=1111 held with instant engine -> grants issued in order 0001, 0010, 0100, 1000, 0001.
REQ-039 Timeout: TIMEOUT=8, eng_done never asserted -> rsp_valid[sel] with rsp_err=1 exactly 8 BUSY cycles after ISSUE; err=1 until err_clr.
REQ-040 Stale done: eng_done held at 1 across ISSUE -> no RESP at bsy_cnt==0, RESP on the following cycle.
REQ-041 Reset in BUSY: rst asserted for one cycle -> all outputs 0, no rsp_valid; next req=1000 gets gnt=1000 (ptr reset to 0).
REQ-042 Done/timeout collision: eng_done first seen at bsy_cnt==TIMEOUT-1 -> rsp_err=0, err stays 0.

Source files
------------

// File: rtl/dot_sched_pkg.sv
// Shared types and defaults for the dot-engine scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   state_t          - scheduler FSM state encoding
//   DOT_TIMEOUT_DEF  - default abandon limit in BUSY cycles
package dot_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_ISSUE = 3'd2,
        ST_BUSY  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam int DOT_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/dot_sched_rr_arbiter.sv
// Round-robin pick of one requester, searching upward from ptr with wrap.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when to take the winner.
//
// Ports:
//   req    - request vector, one bit per requester
//   ptr    - index where the search starts (must be < R)
//   winner - index of the first asserted request at or after ptr
//   valid  - at least one request asserted
module rr_arbiter #(
    parameter  int R  = 4,
    localparam int SW = $clog2(R)
) (
    input  logic [R-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] winner,
    output logic          valid
);

    // Rotate so that bit 0 of w_rot is requester ptr; the first set bit of
    // w_rot is then the offset of the winner from ptr.
    logic [2*R-1:0] w_dbl;
    logic [R-1:0]   w_rot;
    logic [SW-1:0]  w_off;
    logic [SW:0]    w_sum;

    assign w_dbl = {req, req} >> ptr;
    assign w_rot = w_dbl[R-1:0];

    always_comb begin
        w_off = '0;
        // Descending scan: the lowest set offset is the last one written.
        for (int i = R - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SW'(i);
            end
        end
    end

    assign valid = |req;
    assign w_sum = {1'b0, ptr} + {1'b0, w_off};

    // Wrap back into 0..R-1; works for R that is not a power of two.
    assign winner = (w_sum >= (SW + 1)'(R)) ? SW'(w_sum - (SW + 1)'(R))
                                            : w_sum[SW-1:0];

endmodule

// File: rtl/dot_sched.sv
// Shares one dot engine among R requesters: round-robin grant, start, wait, respond.
// Latency: request to response 5 cycles minimum; back-to-back ops every 6 cycles.
// Backpressure: requesters hold req until gnt; req is only looked at in IDLE.
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   req[R]              - level requests;      gnt[R]       - one-hot grant pulse
//   sel[SW]             - owner index, drives the engine operand mux
//   eng_start           - start pulse to engine; eng_done - engine done level
//   rsp_valid[R]        - one-hot completion;  rsp_err      - 1 = timed out
//   err / err_clr       - sticky timeout flag and its clear
//   busy                - high whenever not IDLE
module dot_sched
    import dot_sched_pkg::*;
#(
    parameter  int R       = 4,
    parameter  int TIMEOUT = DOT_TIMEOUT_DEF,
    localparam int SW      = $clog2(R)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [R-1:0]  req,
    output logic [R-1:0]  gnt,
    output logic [SW-1:0] sel,
    output logic          eng_start,
    input  logic          eng_done,
    output logic [R-1:0]  rsp_valid,
    output logic          rsp_err,
    output logic          err,
    input  logic          err_clr,
    output logic          busy
);

    localparam int            CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic [R-1:0]  ONE_LSB = R'(1);

    state_t        r_state;
    logic [SW-1:0] r_ptr;
    logic [SW-1:0] r_sel;
    logic [CW-1:0] r_bsy_cnt;
    logic          r_err;
    logic          r_rsp_err;

    logic [SW-1:0] w_winner;
    logic          w_win_vld;
    logic          w_done_ok;
    logic          w_timeout;
    logic          w_err_set;
    logic [R-1:0]  w_sel_oh;

    rr_arbiter #(
        .R (R)
    ) u_arb (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .valid  (w_win_vld)
    );

    // The first BUSY cycle (count 0) may still see done left high by the
    // previous operation, so only count >= 1 qualifies a done.
    assign w_done_ok = eng_done && (r_bsy_cnt != '0);
    assign w_timeout = (r_bsy_cnt == CNT_MAX);
    // A qualifying done in the timeout cycle beats the timeout.
    assign w_err_set = (r_state == ST_BUSY) && !w_done_ok && w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_bsy_cnt <= '0;
            r_err     <= 1'b0;
            r_rsp_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win_vld) begin
                        r_sel   <= w_winner;
                        r_ptr   <= (w_winner == SW'(R - 1)) ? '0 : w_winner + SW'(1);
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    r_bsy_cnt <= '0;
                    r_state   <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (w_done_ok) begin
                        r_rsp_err <= 1'b0;
                        r_state   <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rsp_err <= 1'b1;
                        r_state   <= ST_RESP;
                    end
                    if (!w_timeout) begin
                        r_bsy_cnt <= r_bsy_cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Set has priority over clear when both land in one cycle.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // Moore outputs decoded from registered state; forced low while rst is
    // held so nothing leaks out before the synchronous reset takes effect.
    assign w_sel_oh  = ONE_LSB << r_sel;
    assign gnt       = (!rst && r_state == ST_GRANT) ? w_sel_oh : '0;
    assign eng_start = !rst && (r_state == ST_ISSUE);
    assign rsp_valid = (!rst && r_state == ST_RESP) ? w_sel_oh : '0;
    assign rsp_err   = !rst && (r_state == ST_RESP) && r_rsp_err;
    assign busy      = !rst && (r_state != ST_IDLE);
    assign sel       = r_sel;
    assign err       = r_err;

endmodule

// File: tb/tb_dot_sched.sv
module tb_dot_sched;

    localparam int R  = 4;
    localparam int TO = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       eng_start;
    logic       eng_done;
    logic [3:0] rsp_valid;
    logic       rsp_err;
    logic       err;
    logic       err_clr;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    dot_sched #(
        .R       (R),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .eng_start (eng_start),
        .eng_done  (eng_done),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .err       (err),
        .err_clr   (err_clr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: an operation is a timeline counted from the
    // accepting edge (age 1 = grant cycle, 2 = start cycle, 3.. = engine
    // running, where running cycle n = age-3). The response age is fixed
    // once a qualifying done (n>=1) or the timeout (n==TO-1) is seen.
    // ------------------------------------------------------------------
    int m_active   = 0;
    int m_age      = 0;
    int m_resp_age = 0;
    int m_to       = 0;
    int m_sel      = 0;
    int m_ptr      = 0;
    int m_err      = 0;

    always begin
        int set_evt;
        int found;
        int n;
        logic [31:0] e_oh;
        @(posedge clk);
        set_evt = 0;
        if (rst) begin
            m_active = 0; m_age = 0; m_resp_age = 0; m_to = 0;
            m_sel = 0; m_ptr = 0; m_err = 0;
        end else begin
            if (m_active == 0) begin
                if (req != 4'b0) begin
                    found = 0;
                    for (int k = 0; k < R; k++) begin
                        if (!found && req[(m_ptr + k) % R]) begin
                            m_sel = (m_ptr + k) % R;
                            found = 1;
                        end
                    end
                    m_ptr = (m_sel + 1) % R;
                    m_active = 1; m_age = 1; m_resp_age = 0; m_to = 0;
                end
            end else if (m_age == m_resp_age) begin
                m_active = 0; m_age = 0; m_resp_age = 0;
            end else begin
                if (m_age >= 3 && m_resp_age == 0) begin
                    n = m_age - 3;
                    if (eng_done && n >= 1) begin
                        m_resp_age = m_age + 1; m_to = 0;
                    end else if (n == TO - 1) begin
                        m_resp_age = m_age + 1; m_to = 1; set_evt = 1;
                    end
                end
                m_age++;
            end
            if (set_evt != 0) m_err = 1;
            else if (err_clr) m_err = 0;
        end
        #1;
        e_oh = 32'd1 << m_sel;
        chk("m_busy",  busy, (m_active != 0) ? 1 : 0);
        chk("m_gnt",   gnt, (m_active != 0 && m_age == 1) ? e_oh : 0);
        chk("m_start", eng_start, (m_active != 0 && m_age == 2) ? 1 : 0);
        chk("m_rsp",   rsp_valid, (m_active != 0 && m_age == m_resp_age) ? e_oh : 0);
        chk("m_rerr",  rsp_err, (m_active != 0 && m_age == m_resp_age && m_to != 0) ? 1 : 0);
        chk("m_sel",   sel, m_sel);
        chk("m_err",   err, m_err);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed literal expectations.
    // ------------------------------------------------------------------
    initial begin
        int n;
        logic [3:0] exp_g [5];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

        rst = 1'b1; req = 4'b0; eng_done = 1'b0; err_clr = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_start", eng_start, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_rerr", rsp_err, 0);
        chk("rst_sel", sel, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Single request, engine done 3 cycles after start.
        req = 4'b0010;
        tick();
        chk("s1_gnt", gnt, 4'b0010);
        chk("s1_sel", sel, 1);
        req = 4'b0;
        tick();
        chk("s1_start", eng_start, 1);
        tick(); tick(); tick();
        eng_done = 1'b1;
        tick();
        chk("s1_rsp", rsp_valid, 4'b0010);
        chk("s1_rerr", rsp_err, 0);
        eng_done = 1'b0;
        tick();
        chk("s1_idle", busy, 0);

        // Fairness with instant engine; done held high across ISSUE.
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111; eng_done = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin tick(); n++; end while (gnt == 4'b0 && n < 20);
            chk("fair_gnt_wait", n, (k == 0) ? 1 : 2);
            chk("fair_gnt", gnt, exp_g[k]);
            n = 0;
            do begin tick(); n++; end while (rsp_valid == 4'b0 && n < 20);
            chk("fair_rsp_lat", n, 4);
            chk("fair_rsp", rsp_valid, exp_g[k]);
            chk("fair_rerr", rsp_err, 0);
        end
        req = 4'b0; eng_done = 1'b0;
        tick(); tick();

        // Timeout: ptr is 1, so requester 2 wins.
        req = 4'b0100;
        tick();
        chk("to_gnt", gnt, 4'b0100);
        req = 4'b0;
        tick();
        chk("to_start", eng_start, 1);
        n = 0;
        do begin tick(); n++; end while (rsp_valid == 4'b0 && n < 20);
        chk("to_lat", n, 9);
        chk("to_rsp", rsp_valid, 4'b0100);
        chk("to_rerr", rsp_err, 1);
        chk("to_err", err, 1);
        tick(); tick();
        chk("to_err_sticky", err, 1);
        chk("to_idle", busy, 0);
        err_clr = 1'b1;
        tick();
        chk("to_err_clr", err, 0);
        err_clr = 1'b0;

        // Timeout while err_clr held: set wins, then clear takes effect.
        err_clr = 1'b1;
        req = 4'b1000;
        tick();
        chk("sw_gnt", gnt, 4'b1000);
        req = 4'b0;
        tick();
        n = 0;
        do begin tick(); n++; end while (rsp_valid == 4'b0 && n < 20);
        chk("sw_lat", n, 9);
        chk("sw_err_set", err, 1);
        tick();
        chk("sw_err_clr", err, 0);
        err_clr = 1'b0;

        // Done first seen in the timeout cycle: done wins.
        req = 4'b0001;
        tick();
        chk("col_gnt", gnt, 4'b0001);
        req = 4'b0;
        tick();
        repeat (8) tick();
        eng_done = 1'b1;
        tick();
        chk("col_rsp", rsp_valid, 4'b0001);
        chk("col_rerr", rsp_err, 0);
        chk("col_err", err, 0);
        eng_done = 1'b0;
        tick();

        // Reset in BUSY abandons the op; pointer restarts at 0.
        req = 4'b0010;
        tick();
        chk("rb_gnt", gnt, 4'b0010);
        req = 4'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("rb_busy", busy, 0);
        chk("rb_rsp", rsp_valid, 0);
        chk("rb_start", eng_start, 0);
        chk("rb_sel", sel, 0);
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("rb_no_rsp", rsp_valid, 0);
        end
        req = 4'b1000;
        tick();
        chk("rb_gnt2", gnt, 4'b1000);

        // A request raised and dropped while busy is never granted.
        req = 4'b0;
        tick();
        req = 4'b0001;
        tick(); tick();
        req = 4'b0;
        eng_done = 1'b1;
        tick();
        chk("drop_rsp", rsp_valid, 4'b1000);
        eng_done = 1'b0;
        repeat (4) begin
            tick();
            chk("drop_no_gnt", gnt, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
